// File: rtl/conv_psum_accum.sv
// Per-pixel partial-sum accumulator: sums G signed group partials plus bias, then
// rounds, shifts, optionally applies ReLU and saturates into a one-deep output register.
module conv_psum_accum #(
  parameter int unsigned IN_W  = 32,
  parameter int unsigned ACC_W = 40,
  parameter int unsigned OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic [7:0]              cfg_groups,
  input  logic [4:0]              cfg_shift,
  input  logic                    cfg_relu,
  input  logic signed [IN_W-1:0]  bias,
  input  logic                    in_valid,
  input  logic signed [IN_W-1:0]  in_data,
  output logic                    in_ready,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic signed [OUT_W-1:0] out_data,
  output logic                    out_ovf
);

  localparam logic signed [ACC_W-1:0] SatMax = {{(ACC_W-OUT_W+1){1'b0}}, {(OUT_W-1){1'b1}}};
  localparam logic signed [ACC_W-1:0] SatMin = {{(ACC_W-OUT_W+1){1'b1}}, {(OUT_W-1){1'b0}}};

  logic signed [ACC_W-1:0] r_acc;
  logic [7:0]              r_cnt;
  logic [7:0]              r_g;
  logic                    r_out_valid;
  logic signed [OUT_W-1:0] r_out_data;
  logic                    r_out_ovf;

  logic                    w_accept;
  logic                    w_first;
  logic                    w_last;
  logic [7:0]              w_g_eff;
  logic signed [ACC_W-1:0] w_in_ext;
  logic signed [ACC_W-1:0] w_bias_ext;
  logic signed [ACC_W-1:0] w_sum;
  logic signed [ACC_W-1:0] w_rnd;
  logic signed [ACC_W-1:0] w_pre;
  logic signed [ACC_W-1:0] w_shr;
  logic signed [ACC_W-1:0] w_relu;
  logic signed [OUT_W-1:0] w_q;
  logic                    w_ovf;

  assign in_ready  = !r_out_valid || out_ready;
  assign w_accept  = in_valid && in_ready;
  assign w_first   = (r_cnt == 8'd0);

  // Group count is taken live only on the first beat; later beats use the latched value.
  assign w_g_eff   = w_first ? ((cfg_groups == 8'd0) ? 8'd1 : cfg_groups) : r_g;
  assign w_last    = (r_cnt == (w_g_eff - 8'd1));

  assign w_in_ext   = {{(ACC_W-IN_W){in_data[IN_W-1]}}, in_data};
  assign w_bias_ext = {{(ACC_W-IN_W){bias[IN_W-1]}}, bias};
  assign w_sum      = w_first ? (w_bias_ext + w_in_ext) : (r_acc + w_in_ext);

  always_comb begin
    w_rnd = '0;
    if (cfg_shift != 5'd0) begin
      w_rnd = ACC_W'(1) << (cfg_shift - 5'd1);
    end
  end

  assign w_pre  = w_sum + w_rnd;
  assign w_shr  = w_pre >>> cfg_shift;
  assign w_relu = (cfg_relu && w_shr[ACC_W-1]) ? '0 : w_shr;

  always_comb begin
    w_q   = w_relu[OUT_W-1:0];
    w_ovf = 1'b0;
    if (w_relu > SatMax) begin
      w_q   = SatMax[OUT_W-1:0];
      w_ovf = 1'b1;
    end else if (w_relu < SatMin) begin
      w_q   = SatMin[OUT_W-1:0];
      w_ovf = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_acc <= '0;
      r_cnt <= 8'd0;
      r_g   <= 8'd1;
    end else if (w_accept) begin
      r_acc <= w_sum;
      r_cnt <= w_last ? 8'd0 : (r_cnt + 8'd1);
      if (w_first) begin
        r_g <= w_g_eff;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_out_valid <= 1'b0;
      r_out_data  <= '0;
      r_out_ovf   <= 1'b0;
    end else if (w_accept && w_last) begin
      r_out_valid <= 1'b1;
      r_out_data  <= w_q;
      r_out_ovf   <= w_ovf;
    end else if (out_ready) begin
      r_out_valid <= 1'b0;
    end
  end

  assign out_valid = r_out_valid;
  assign out_data  = r_out_data;
  assign out_ovf   = r_out_ovf;

endmodule

// File: tb/tb_conv_psum_accum.sv
// Directed bench for conv_psum_accum with hand-computed expected results.
module tb_conv_psum_accum;

  logic               clk;
  logic               rst_n;
  logic [7:0]         cfg_groups;
  logic [4:0]         cfg_shift;
  logic               cfg_relu;
  logic signed [31:0] bias;
  logic               in_valid;
  logic signed [31:0] in_data;
  logic               in_ready;
  logic               out_valid;
  logic               out_ready;
  logic signed [15:0] out_data;
  logic               out_ovf;

  int n_checks = 0;
  int n_fails  = 0;

  conv_psum_accum #(
    .IN_W (32),
    .ACC_W(40),
    .OUT_W(16)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_groups(cfg_groups),
    .cfg_shift (cfg_shift),
    .cfg_relu  (cfg_relu),
    .bias      (bias),
    .in_valid  (in_valid),
    .in_data   (in_data),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_ovf   (out_ovf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic signed [63:0] obs,
                       input logic signed [63:0] exp);
    n_checks++;
    assert (obs === exp)
    else begin
      n_fails++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic beat(input logic signed [31:0] d);
    in_valid = 1'b1;
    in_data  = d;
    tick();
  endtask

  task automatic idle();
    in_valid = 1'b0;
    in_data  = '0;
    tick();
  endtask

  task automatic chk_out(input string tag, input logic v, input logic signed [63:0] d,
                         input logic o);
    check({tag, "_valid"}, out_valid, v);
    if (v) begin
      check({tag, "_data"}, out_data, d);
      check({tag, "_ovf"}, out_ovf, o);
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    cfg_groups = 8'd4;
    cfg_shift  = 5'd0;
    cfg_relu   = 1'b0;
    bias       = '0;
    in_valid   = 1'b0;
    in_data    = '0;
    out_ready  = 1'b1;

    // Reset state
    repeat (3) tick();
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_ovf", out_ovf, 0);
    check("rst_in_ready", in_ready, 1);
    rst_n = 1'b1;
    tick();

    // G=4, bias=10, in 1..4 -> 20
    cfg_groups = 8'd4;
    bias       = 32'sd10;
    beat(1);  chk_out("g4_b1", 0, 0, 0);
    beat(2);  chk_out("g4_b2", 0, 0, 0);
    beat(3);  chk_out("g4_b3", 0, 0, 0);
    beat(4);  chk_out("g4_out", 1, 20, 0);
    idle();   chk_out("g4_clear", 0, 0, 0);

    // G=1, ReLU: 5 then -7 -> 5 then 0
    cfg_groups = 8'd1;
    bias       = '0;
    cfg_relu   = 1'b1;
    beat(5);  chk_out("relu_pos", 1, 5, 0);
    beat(-7); chk_out("relu_neg", 1, 0, 0);
    idle();   chk_out("relu_clear", 0, 0, 0);

    // Rounding shift: 6 -> 2, -6 -> -1, shift=1: 3 -> 2
    cfg_relu  = 1'b0;
    cfg_shift = 5'd2;
    beat(6);  chk_out("shr_pos", 1, 2, 0);
    beat(-6); chk_out("shr_neg", 1, -1, 0);
    cfg_shift = 5'd1;
    beat(3);  chk_out("shr1_round", 1, 2, 0);
    cfg_shift = 5'd0;
    idle();

    // Saturation at G=2
    cfg_groups = 8'd2;
    beat(30000);  chk_out("sat_hi_b1", 0, 0, 0);
    beat(30000);  chk_out("sat_hi", 1, 32767, 1);
    beat(-40000); chk_out("sat_lo_b1", 0, 0, 0);
    beat(0);      chk_out("sat_lo", 1, -32768, 1);
    beat(32767);  beat(0); chk_out("sat_edge_max", 1, 32767, 0);
    beat(-32768); beat(0); chk_out("sat_edge_min", 1, -32768, 0);
    idle();

    // ReLU keeps a large negative from flagging overflow
    cfg_relu = 1'b1;
    beat(-40000); beat(-1); chk_out("relu_no_ovf", 1, 0, 0);
    cfg_relu = 1'b0;
    idle();

    // cfg_groups=0 behaves as 1
    cfg_groups = 8'd0;
    beat(7);  chk_out("g0_as_1", 1, 7, 0);
    idle();

    // Mid-pixel cfg_groups change ignored until next first beat
    cfg_groups = 8'd3;
    beat(10); cfg_groups = 8'd1;
    beat(20); chk_out("gchg_b2", 0, 0, 0);
    beat(30); chk_out("gchg_out", 1, 60, 0);
    idle();

    // Backpressure: hold for 3 cycles, then release with new last beat on same edge
    cfg_groups = 8'd1;
    out_ready  = 1'b0;
    beat(100); chk_out("bp_load", 1, 100, 0);
    in_valid = 1'b1;
    in_data  = 200;
    for (int i = 0; i < 3; i++) begin
      check("bp_in_ready", in_ready, 0);
      tick();
      chk_out("bp_hold", 1, 100, 0);
    end
    out_ready = 1'b1;
    #1;
    check("bp_release_ready", in_ready, 1);
    tick();   chk_out("bp_nobubble", 1, 200, 0);
    beat(300); chk_out("bp_next", 1, 300, 0);
    idle();   chk_out("bp_clear", 0, 0, 0);

    // Reset mid-pixel discards partial accumulation
    cfg_groups = 8'd4;
    bias       = 32'sd50;
    beat(1);
    beat(1);
    in_valid = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("midrst_valid", out_valid, 0);
    check("midrst_in_ready", in_ready, 1);
    tick();
    rst_n = 1'b1;
    bias  = '0;
    tick();
    beat(1); beat(1); chk_out("midrst_b2", 0, 0, 0);
    beat(1); beat(1); chk_out("midrst_out", 1, 4, 0);
    idle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule

// File: doc/conv_psum_accum.md
CONV_PSUM_ACCUM -- requirements
Module: conv_psum_accum

Interface
REQ-001 Parameter IN_W, default 32, SHALL set the width of the incoming group partial sum (signed, two's complement).
REQ-002 Parameter ACC_W, default 40, SHALL set the internal accumulator width (signed).
REQ-003 Parameter OUT_W, default 16, SHALL set the width of the quantised output (signed).
REQ-004 clk  in  1  SHALL be the single clock; all state SHALL update on its rising edge.
REQ-005 rst_n  in  1  SHALL be the reset: asynchronous assert, active-low.
REQ-006 cfg_groups  in  8  SHALL give the number of partial sums per output pixel; 0 SHALL be treated as 1.
REQ-007 cfg_shift  in  5  SHALL give the arithmetic right-shift applied before saturation.
REQ-008 cfg_relu  in  1  SHALL enable ReLU when 1.
REQ-009 bias  in  IN_W  SHALL be the signed per-pixel bias, sampled on the first beat of each pixel.
REQ-010 in_valid  in  1  SHALL qualify in_data.
REQ-011 in_data  in  IN_W  SHALL carry one signed group partial sum per accepted beat.
REQ-012 in_ready  out  1  SHALL indicate a beat can be accepted.
REQ-013 out_valid  out  1  SHALL qualify out_data and out_ovf.
REQ-014 out_ready  in  1  SHALL indicate the consumer takes the output this cycle.
REQ-015 out_data  out  OUT_W  SHALL carry the quantised signed pixel result.
REQ-016 out_ovf  out  1  SHALL flag that out_data was saturated.

Function
REQ-017 A beat SHALL be accepted when in_valid && in_ready; in_ready SHALL equal !out_valid || out_ready (combinational).
REQ-018 The block SHALL keep an 8-bit beat counter cnt and a latched group count G; on the first beat (cnt==0), G SHALL latch max(cfg_groups,1) and acc SHALL load sext(bias)+sext(in_data).
REQ-019 On a non-first accepted beat, acc SHALL become acc+sext(in_data), with all additions at ACC_W, wrapping modulo 2^ACC_W.
REQ-020 The beat with cnt==G-1 SHALL be the last beat; it SHALL reset cnt to 0, and sum SHALL be the value acc would take on that beat.
REQ-021 Rounding SHALL compute r = (sum + (cfg_shift>0 ? 1<<(cfg_shift-1) : 0)) >>> cfg_shift.
REQ-022 If cfg_relu==1 and r<0, r SHALL become 0.
REQ-023 r SHALL saturate to [-2^(OUT_W-1), 2^(OUT_W-1)-1]; out_ovf SHALL be 1 iff clipping occurred.
REQ-024 out_data, out_ovf and out_valid=1 SHALL register on the edge that accepts the last beat, so the latency is 1 cycle from last-beat acceptance.
REQ-025 out_valid SHALL clear on an edge with out_ready=1 unless a new last beat is accepted on that same edge, in which case the new result SHALL load with no bubble.
REQ-026 While out_valid && !out_ready, out_data and out_ovf SHALL hold stable and no beat SHALL be accepted.
REQ-027 cfg_shift and cfg_relu SHALL be used as presented on the last beat; cfg_groups changes mid-pixel SHALL have no effect until the next first beat.
REQ-028 Back-to-back pixels with G=1 SHALL sustain one output per cycle when out_ready=1.

Reset
REQ-029 While rst_n=0: acc=0, cnt=0, G=1, out_valid=0, out_data=0, out_ovf=0; in_ready SHALL read 1.
REQ-030 Reset mid-pixel SHALL discard the partial accumulation; the first beat after release SHALL be treated as a first beat.

Verification
REQ-031 G=4, bias=10, shift=0, relu=0, in 1,2,3,4 back-to-back, out_ready=1 -> out_valid for 1 cycle, one cycle after the 4th beat, out_data=20, out_ovf=0.
REQ-032 G=1, bias=0, relu=1, in 5 then -7 on consecutive cycles -> outputs 5 then 0 on consecutive cycles.
REQ-033 G=1, shift=2, in 6 then -6 -> outputs 2 then -1.
REQ-034 G=2, OUT_W=16, in 30000,30000 -> out_data=32767, out_ovf=1; in -40000,0 -> out_data=-32768, out_ovf=1.
REQ-035 Result held with out_ready=0 for 3 cycles -> in_ready=0 and out_data stable throughout; out_ready=1 with a new last beat on the same edge -> next result loads with no bubble and no loss.
REQ-036 G=4, 2 beats accepted, rst_n pulsed low -> out_valid=0; then in 1,1,1,1 with bias=0 -> out_data=4.
